// File: rtl/timer_dev_if.sv
// timer_dev_if -- CPU-side register bus for timer_dev.
//   sel   : chip select from the system bridge
//   addr  : word offset within the 16-byte window (CPU addr[3:2])
//   we    : write strobe, effective only with sel
//   wdata : 32-bit write data
//   rdata : combinational read data for addr
//   irq   : interrupt request
interface timer_dev_if;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output sel, addr, we, wdata, input rdata, irq);
  modport slave  (input sel, addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_dev.sv
// timer_dev -- memory-mapped down-counting timer with one-shot and
// auto-reload modes and a maskable interrupt.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : timer_dev_if slave (sel/addr/we/wdata in, rdata/irq out)
// Register map: 0 CTRL {IM,Mode[1:0],Enable}, 1 PRESET, 2 COUNT (RO),
// 3 reserved (reads 0).
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      r_state, w_nxt_state;
  logic        r_en, w_nxt_en;
  logic [1:0]  r_mode, w_nxt_mode;
  logic        r_im, w_nxt_im;
  logic [31:0] r_preset, w_nxt_preset;
  logic [31:0] r_count, w_nxt_count;
  logic        r_sticky, w_nxt_sticky;

  logic        w_wr_ctrl, w_wr_preset, w_autoreload;

  assign w_wr_ctrl    = bus.sel && bus.we && (bus.addr == 2'd0);
  assign w_wr_preset  = bus.sel && bus.we && (bus.addr == 2'd1);
  // Mode codes 10/11 fall back to one-shot behaviour.
  assign w_autoreload = (r_mode == 2'b01);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_en     <= 1'b0;
      r_mode   <= 2'b00;
      r_im     <= 1'b0;
      r_preset <= '0;
      r_count  <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_en     <= w_nxt_en;
      r_mode   <= w_nxt_mode;
      r_im     <= w_nxt_im;
      r_preset <= w_nxt_preset;
      r_count  <= w_nxt_count;
      r_sticky <= w_nxt_sticky;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_en     = r_en;
    w_nxt_mode   = r_mode;
    w_nxt_im     = r_im;
    w_nxt_preset = r_preset;
    w_nxt_count  = r_count;
    w_nxt_sticky = r_sticky;

    case (r_state)
      IDLE: if (r_en) w_nxt_state = LOAD;
      LOAD: begin
        w_nxt_count = r_preset;
        w_nxt_state = CNT;
      end
      CNT: begin
        if (!r_en) begin
          w_nxt_state = IDLE;
        end else if (r_count > 32'd1) begin
          w_nxt_count = r_count - 32'd1;
        end else begin
          // Expire at 1 (or 0 for PRESET=0); never wrap below zero.
          w_nxt_count = '0;
          w_nxt_state = INT;
        end
      end
      INT: begin
        if (w_autoreload) begin
          w_nxt_state = LOAD;
        end else begin
          w_nxt_en     = 1'b0;
          w_nxt_sticky = 1'b1;
          w_nxt_state  = IDLE;
        end
      end
      default: w_nxt_state = IDLE;
    endcase

    // CPU writes are applied last so they override the FSM's own updates
    // to Enable and the sticky flag in the same cycle.
    if (w_wr_ctrl) begin
      w_nxt_en   = bus.wdata[0];
      w_nxt_mode = bus.wdata[2:1];
      w_nxt_im   = bus.wdata[3];
    end
    if (w_wr_preset) w_nxt_preset = bus.wdata;
    if (w_wr_ctrl || w_wr_preset) w_nxt_sticky = 1'b0;
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0:    bus.rdata = {28'd0, r_im, r_mode, r_en};
      2'd1:    bus.rdata = r_preset;
      2'd2:    bus.rdata = r_count;
      default: bus.rdata = '0;
    endcase
  end

  assign bus.irq = r_im && ((r_state == INT) || r_sticky);

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  timer_dev_if bus ();
  timer_dev dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  // Reference model: register file plus a description of where the timer
  // is in its life cycle (waiting to load, counting, just expired).
  logic [31:0] m_preset, m_count;
  logic        m_en, m_im, m_sticky;
  logic [1:0]  m_mode;
  bit          m_load, m_cnt, m_exp;

  function automatic vec_t mk(logic r, logic s, logic w, logic [1:0] a,
                              logic [31:0] d, logic [31:0] er, logic ei);
    vec_t v;
    v.rst_n = r; v.sel = s; v.we = w; v.addr = a; v.wdata = d;
    v.exp_rd = er; v.exp_irq = ei;
    return v;
  endfunction

  function automatic logic [31:0] m_rd(logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    return m_im && (m_exp || m_sticky);
  endfunction

  task automatic model_step(input logic rn, input logic s, input logic w,
                            input logic [1:0] a, input logic [31:0] d);
    logic wc, wp, n_en, n_sticky;
    logic [31:0] n_count;
    bit n_load, n_cnt, n_exp;
    if (!rn) begin
      m_preset = 0; m_count = 0; m_en = 0; m_im = 0; m_mode = 0;
      m_sticky = 0; m_load = 0; m_cnt = 0; m_exp = 0;
    end else begin
      wc = s && w && (a == 2'd0);
      wp = s && w && (a == 2'd1);
      n_en = m_en; n_sticky = m_sticky; n_count = m_count;
      n_load = 0; n_cnt = 0; n_exp = 0;
      if (m_exp) begin
        if (m_mode == 2'b01) n_load = 1;
        else begin n_en = 0; n_sticky = 1; end
      end else if (m_load) begin
        n_count = m_preset; n_cnt = 1;
      end else if (m_cnt) begin
        if (m_en) begin
          if (m_count > 1) begin n_count = m_count - 1; n_cnt = 1; end
          else begin n_count = 0; n_exp = 1; end
        end
      end else if (m_en) begin
        n_load = 1;
      end
      if (wc) begin n_en = d[0]; m_mode = d[2:1]; m_im = d[3]; end
      if (wp) m_preset = d;
      if (wc || wp) n_sticky = 0;
      m_en = n_en; m_sticky = n_sticky; m_count = n_count;
      m_load = n_load; m_cnt = n_cnt; m_exp = n_exp;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  // One clock edge with the given inputs; returns at the following negedge
  // with the inputs still applied.
  task automatic drive(input logic r, input logic s, input logic w,
                       input logic [1:0] a, input logic [31:0] d);
    reset = r; bus.sel = s; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a,
                        input logic [31:0] er, input logic ei);
    bus.sel = 0; bus.we = 0; bus.addr = a;
    #1;
    chk({name, ".rd"}, bus.rdata, er);
    chk({name, ".irq"}, {31'd0, bus.irq}, {31'd0, ei});
  endtask

  initial begin
    reset = 0; bus.sel = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    @(negedge clk);

    // One-shot PRESET=3, then auto-reload PRESET=2.
    tbl.push_back(mk(0,0,0,0,0,          0,0));
    tbl.push_back(mk(1,1,1,1,3,          3,0));
    tbl.push_back(mk(1,1,1,0,32'h9,      9,0));
    tbl.push_back(mk(1,0,0,2,0,          0,0));
    tbl.push_back(mk(1,0,0,2,0,          3,0));
    tbl.push_back(mk(1,0,0,2,0,          2,0));
    tbl.push_back(mk(1,0,0,2,0,          1,0));
    tbl.push_back(mk(1,0,0,2,0,          0,1));
    tbl.push_back(mk(1,0,0,0,0,          8,1));
    tbl.push_back(mk(1,0,0,0,0,          8,1));
    tbl.push_back(mk(1,1,1,1,5,          5,0));
    tbl.push_back(mk(1,1,1,1,2,          2,0));
    tbl.push_back(mk(1,1,1,0,32'hB,      32'hB,0));
    tbl.push_back(mk(1,0,0,2,0,          0,0));
    tbl.push_back(mk(1,0,0,2,0,          2,0));
    tbl.push_back(mk(1,0,0,2,0,          1,0));
    tbl.push_back(mk(1,0,0,2,0,          0,1));
    tbl.push_back(mk(1,0,0,2,0,          0,0));
    tbl.push_back(mk(1,0,0,2,0,          2,0));
    tbl.push_back(mk(1,0,0,2,0,          1,0));
    tbl.push_back(mk(1,0,0,2,0,          0,1));
    tbl.push_back(mk(1,0,0,2,0,          0,0));
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d.rd", i), bus.rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d.irq", i), {31'd0, bus.irq}, {31'd0, tbl[i].exp_irq});
    end

    // Mid-count CTRL disable, COUNT write ignored, reserved reads 0, reload.
    drive(0,0,0,0,0);
    drive(1,1,1,1,10);
    drive(1,1,1,0,9);
    drive(1,0,0,2,0);
    drive(1,0,0,2,0);  chk("cnt.first", bus.rdata, 10);
    drive(1,0,0,2,0);
    drive(1,1,1,2,32'hFFFF_FFFF); chk("cnt.ro", bus.rdata, 8);
    drive(1,1,1,3,32'h1234_5678); chk("rsvd.rd", bus.rdata, 0);
    drive(1,1,1,0,8);  chk("dis.ctrl", bus.rdata, 8);
    drive(1,0,0,2,0);  chk("dis.frz1", bus.rdata, 6);
    drive(1,0,0,2,0);  chk("dis.frz2", bus.rdata, 6);
    drive(1,1,1,0,9);
    drive(1,0,0,2,0);  chk("re.load", bus.rdata, 6);
    drive(1,0,0,2,0);  chk("re.cnt", bus.rdata, 10);

    // One-shot with IM=0: no irq; enabling IM by a CTRL write clears sticky.
    drive(0,0,0,0,0);
    drive(1,1,1,1,1);
    drive(1,1,1,0,1);
    drive(1,0,0,2,0);
    drive(1,0,0,2,0);
    drive(1,0,0,2,0);  rd_chk("im0.int", 2, 0, 0);
    drive(1,0,0,0,0);  rd_chk("im0.done", 0, 0, 0);
    drive(1,1,1,0,8);  rd_chk("im0.setim", 0, 8, 0);
    drive(1,0,0,0,0);  rd_chk("im0.after", 0, 8, 0);

    // CTRL write during INT wins over the Enable clear; PRESET write during
    // INT suppresses the sticky flag.
    drive(0,0,0,0,0);
    drive(1,1,1,0,9);
    drive(1,0,0,2,0);
    drive(1,0,0,2,0);
    drive(1,0,0,2,0);  rd_chk("p0.int", 2, 0, 1);
    drive(1,1,1,0,9);  rd_chk("int.wr", 0, 9, 0);
    drive(1,0,0,0,0);
    drive(1,0,0,0,0);
    drive(1,0,0,0,0);  rd_chk("p0.int2", 0, 9, 1);
    drive(1,1,1,1,0);  rd_chk("int.pre", 0, 8, 0);
    drive(1,0,0,0,0);  rd_chk("int.pre2", 0, 8, 0);

    // Reset mid-count overrides a simultaneous CTRL write.
    drive(1,1,1,1,8);
    drive(1,1,1,0,9);
    drive(1,0,0,2,0);
    drive(1,0,0,2,0);
    drive(1,0,0,2,0);
    drive(1,0,0,2,0);
    drive(1,0,0,2,0);  chk("rst.pre5", bus.rdata, 5);
    drive(0,1,1,0,32'hF);
    rd_chk("rst.ctrl", 0, 0, 0);
    rd_chk("rst.pre", 1, 0, 0);
    rd_chk("rst.cnt", 2, 0, 0);

    // Randomised run against the reference model.
    drive(0,0,0,0,0);
    model_step(0,0,0,0,0);
    for (int n = 0; n < 4000; n++) begin
      logic r, s, w;
      logic [1:0] a;
      logic [31:0] d;
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 2) == 0);
      a = 2'($urandom_range(0, 3));
      if (a == 2'd1) d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
      else if (a == 2'd0 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 15)) | 32'h1;
      else d = $urandom;
      reset = r; bus.sel = s; bus.we = w; bus.addr = a; bus.wdata = d;
      #1;
      chk("rnd.rd", bus.rdata, m_rd(a));
      chk("rnd.irq", {31'd0, bus.irq}, {31'd0, m_irq()});
      @(posedge clk);
      model_step(r, s, w, a, d);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
